// File: rtl/sap_pkg.sv
// Shared defaults and the command classes decoded from the PC control strobes.
package sap_pkg;

  localparam int ADDR_W_DEF      = 8;
  localparam int STACK_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_INC,
    CMD_LOAD,
    CMD_CALL,
    CMD_RET,
    CMD_ILLEGAL
  } cmd_e;

  // CALL/RET outrank Lp, which outranks Cp; CALL together with RET is illegal.
  function automatic cmd_e decode_cmd(input logic cp, input logic lp,
                                      input logic call, input logic ret);
    cmd_e c;
    if (call && ret)  c = CMD_ILLEGAL;
    else if (call)    c = CMD_CALL;
    else if (ret)     c = CMD_RET;
    else if (lp)      c = CMD_LOAD;
    else if (cp)      c = CMD_INC;
    else              c = CMD_NONE;
    return c;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO: depth counter is reset, entry storage is not.
module pc_ret_stack
  import sap_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               CLK_bar,
  input  logic               CLR_bar,
  input  logic               push,
  input  logic               pop,
  input  logic [ADDR_W-1:0]  din,
  output logic [ADDR_W-1:0]  top,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);

  // Sized to the full index range so the depth counter indexes it directly.
  logic [ADDR_W-1:0]  mem [0:(1 << DEPTH_W)-1];
  logic [DEPTH_W-1:0] top_idx;

  assign top_idx = depth - DEPTH_W'(1);
  assign top     = mem[top_idx];
  assign empty   = (depth == '0);
  assign full    = (depth == DEPTH_W'(STACK_DEPTH));

  always_ff @(posedge CLK_bar or negedge CLR_bar) begin
    if (!CLR_bar) begin
      depth <= '0;
    end else if (push && !full) begin
      depth <= depth + DEPTH_W'(1);
    end else if (pop && !empty) begin
      depth <= depth - DEPTH_W'(1);
    end
  end

  always_ff @(posedge CLK_bar) begin
    if (push && !full) begin
      mem[depth] <= din;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with call/return stack, sticky error flags and a tri-state bus driver.
module pc_stack_unit
  import sap_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic              CLK_bar,
  input  logic              CLR_bar,
  input  logic              Cp,
  input  logic              Ep,
  input  logic              Lp,
  input  logic              CALL,
  input  logic              RET,
  input  logic [ADDR_W-1:0] W_in,
  output logic [ADDR_W-1:0] W_bus,
  output logic [ADDR_W-1:0] pc,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              err_ovf,
  output logic              err_unf,
  output logic              err_cmd
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  cmd_e               cmd;
  logic               push;
  logic               pop;
  logic [ADDR_W-1:0]  stk_top;
  logic [DEPTH_W-1:0] stk_depth;

  assign cmd  = decode_cmd(Cp, Lp, CALL, RET);
  assign push = (cmd == CMD_CALL) && !stk_full;
  assign pop  = (cmd == CMD_RET)  && !stk_empty;

  pc_ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH),
    .DEPTH_W     (DEPTH_W)
  ) u_stack (
    .CLK_bar (CLK_bar),
    .CLR_bar (CLR_bar),
    .push    (push),
    .pop     (pop),
    .din     (pc),
    .top     (stk_top),
    .depth   (stk_depth),
    .full    (stk_full),
    .empty   (stk_empty)
  );

  always_ff @(posedge CLK_bar or negedge CLR_bar) begin
    if (!CLR_bar) begin
      pc      <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
      err_cmd <= 1'b0;
    end else begin
      case (cmd)
        CMD_INC:  pc <= pc + ADDR_W'(1);
        CMD_LOAD: pc <= W_in;
        CMD_CALL: begin
          if (stk_full) err_ovf <= 1'b1;
          else          pc      <= W_in;
        end
        CMD_RET: begin
          if (stk_empty) err_unf <= 1'b1;
          else           pc      <= stk_top;
        end
        CMD_ILLEGAL: err_cmd <= 1'b1;
        default: ;
      endcase
    end
  end

  assign W_bus = Ep ? pc : {ADDR_W{1'bz}};

endmodule
